// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with pending scoreboard and a sequential clear engine.
// Define REG_FILE_SB_BYPASS_EN to forward same-cycle writes (and their pending state) onto the read ports.
module reg_file_sb #(
    parameter int N        = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] a1,
    input  logic [AW-1:0] a2,
    output logic [N-1:0]  rd1,
    output logic [N-1:0]  rd2,
    output logic          pend1,
    output logic          pend2,
    input  logic [AW-1:0] a3,
    input  logic [N-1:0]  wd3,
    input  logic          we,
    input  logic          mark_en,
    input  logic [AW-1:0] mark_addr,
    input  logic          clr_req,
    output logic          ready
);

    localparam int NREG = 2 ** AW;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [NREG-1:0] pend;
    logic [N-1:0]    regFile [NREG];

    logic wrValid;
    logic wrOk;
    logic markOk;

    // A write that would land in the array; clr_req additionally drops it.
    assign wrValid = (state == RUN) && we && !((ZERO_REG != 0) && (a3 == '0));
    assign wrOk    = wrValid && !clr_req;
    assign markOk  = mark_en && !((ZERO_REG != 0) && (mark_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
            pend  <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    pend <= '0;
                    cnt  <= cnt + AW'(1);
                    if (cnt == '1) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        pend  <= '0;
                        ready <= 1'b0;
                    end else begin
                        // Mark is applied last so a new producer wins over a retiring one.
                        if (we)
                            pend[a3] <= 1'b0;
                        if (markOk)
                            pend[mark_addr] <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    pend  <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // The array carries no reset; the clear engine walks it instead.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            regFile[cnt] <= '0;
        else if (wrOk)
            regFile[a3] <= wd3;
    end

    always_comb begin
        rd1   = regFile[a1];
        pend1 = pend[a1];
        if ((ZERO_REG != 0) && (a1 == '0))
            rd1 = '0;
`ifdef REG_FILE_SB_BYPASS_EN
        if (wrValid && (a3 == a1)) begin
            rd1   = wd3;
            pend1 = markOk && (mark_addr == a3);
        end
`endif
        if (state == CLEAR) begin
            rd1   = '0;
            pend1 = 1'b0;
        end
    end

    always_comb begin
        rd2   = regFile[a2];
        pend2 = pend[a2];
        if ((ZERO_REG != 0) && (a2 == '0))
            rd2 = '0;
`ifdef REG_FILE_SB_BYPASS_EN
        if (wrValid && (a3 == a2)) begin
            rd2   = wd3;
            pend2 = markOk && (mark_addr == a3);
        end
`endif
        if (state == CLEAR) begin
            rd2   = '0;
            pend2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed vector table, clear/reset sequences, random run vs. a model.
module tb_reg_file_sb;

    localparam bit BYP =
`ifdef REG_FILE_SB_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  a1, a2, a3, mark_addr;
    logic [31:0] wd3;
    logic        we, mark_en, clr_req;
    logic [31:0] rd1, rd2;
    logic        pend1, pend2, ready;

    reg_file_sb #(.N(32), .AW(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
        .pend1(pend1), .pend2(pend2),
        .a3(a3), .wd3(wd3), .we(we),
        .mark_en(mark_en), .mark_addr(mark_addr),
        .clr_req(clr_req), .ready(ready)
    );

    always #5 clk = ~clk;

    // Reference model: architectural contents plus cycles left until the clear completes.
    logic [31:0] mem [32];
    logic        pendM [32];
    int          clearLeft;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic        we;
        logic        markEn;
        logic [4:0]  markAddr;
        logic [31:0] expRd1;
        logic        expPend1;
    } vec_t;

    vec_t tbl [13];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        clearLeft = 32;
        for (int i = 0; i < 32; i++) begin
            mem[i]   = '0;
            pendM[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] expRd(input logic [4:0] a);
        if (clearLeft != 0 || a == 5'd0)
            return '0;
        if (BYP && we && a3 == a)
            return wd3;
        return mem[a];
    endfunction

    function automatic logic expPend(input logic [4:0] a);
        if (clearLeft != 0 || a == 5'd0)
            return 1'b0;
        if (BYP && we && a3 == a)
            return mark_en && (mark_addr == a);
        return pendM[a];
    endfunction

    task automatic applyStimulus(input logic [4:0] ia1, input logic [4:0] ia2,
                                 input logic [4:0] ia3, input logic [31:0] iwd,
                                 input logic iwe, input logic imark,
                                 input logic [4:0] imaddr, input logic iclr);
        a1 = ia1; a2 = ia2; a3 = ia3; wd3 = iwd;
        we = iwe; mark_en = imark; mark_addr = imaddr; clr_req = iclr;
    endtask

    task automatic checkOutput(input string tag);
        @(negedge clk);
        cmp({tag, ".rd1"},   rd1,   expRd(a1));
        cmp({tag, ".rd2"},   rd2,   expRd(a2));
        cmp({tag, ".pend1"}, 32'(pend1), 32'(expPend(a1)));
        cmp({tag, ".pend2"}, 32'(pend2), 32'(expPend(a2)));
        cmp({tag, ".ready"}, 32'(ready), 32'(clearLeft == 0));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n)
            modelReset();
        else if (clearLeft > 0)
            clearLeft--;
        else if (clr_req)
            modelReset();
        else begin
            if (we && a3 != 5'd0)
                mem[a3] = wd3;
            if (we)
                pendM[a3] = 1'b0;
            if (mark_en && mark_addr != 5'd0)
                pendM[mark_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic waitClear(input string tag);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(5'd3, 5'd4, 5'd4, 32'hFF, 1'b1, 1'b1, 5'd3, 1'b0);
            checkOutput(tag);
            cmp({tag, ".busy"}, 32'(ready), 32'd0);
            tick();
        end
        applyStimulus(5'd3, 5'd4, 5'd0, '0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput(tag);
        cmp({tag, ".done"}, 32'(ready), 32'd1);
        cmp({tag, ".r3"}, rd1, 32'd0);
        cmp({tag, ".r4"}, rd2, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{5'd5, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0, BYP ? 32'hDEADBEEF : 32'h0, 1'b0};
        tbl[1]  = '{5'd5, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{5'd0, 5'd0, 32'h1234,     1'b1, 1'b1, 5'd0, 32'h0, 1'b0};
        tbl[3]  = '{5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b0};
        tbl[4]  = '{5'd9, 5'd0, 32'h0,        1'b0, 1'b1, 5'd9, 32'h0, 1'b0};
        tbl[5]  = '{5'd9, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b1};
        tbl[6]  = '{5'd9, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b1};
        tbl[7]  = '{5'd9, 5'd9, 32'h55,       1'b1, 1'b0, 5'd0, BYP ? 32'h55 : 32'h0, !BYP};
        tbl[8]  = '{5'd9, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h55, 1'b0};
        tbl[9]  = '{5'd9, 5'd9, 32'h77,       1'b1, 1'b1, 5'd9, BYP ? 32'h77 : 32'h55, BYP};
        tbl[10] = '{5'd9, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h77, 1'b1};
        tbl[11] = '{5'd3, 5'd3, 32'hA5,       1'b1, 1'b0, 5'd0, BYP ? 32'hA5 : 32'h0, 1'b0};
        tbl[12] = '{5'd3, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'hA5, 1'b0};

        rst_n = 1'b0;
        modelReset();
        applyStimulus(5'd7, 5'd31, 5'd7, 32'h1111, 1'b1, 1'b1, 5'd7, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // Initial clear: 32 busy cycles, ready on the 33rd; writes and marks ignored throughout.
        for (int i = 0; i < 32; i++) begin
            checkOutput("init");
            cmp("init.busy", 32'(ready), 32'd0);
            tick();
        end
        applyStimulus(5'd7, 5'd31, 5'd0, '0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("init");
        cmp("init.ready", 32'(ready), 32'd1);
        cmp("init.r7", rd1, 32'd0);
        cmp("init.r31", rd2, 32'd0);
        tick();

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].a1, 5'd31, tbl[i].a3, tbl[i].wd3, tbl[i].we,
                          tbl[i].markEn, tbl[i].markAddr, 1'b0);
            checkOutput($sformatf("tbl%0d", i));
            cmp($sformatf("tbl%0d.rd1", i), rd1, tbl[i].expRd1);
            cmp($sformatf("tbl%0d.pend1", i), 32'(pend1), 32'(tbl[i].expPend1));
            cmp($sformatf("tbl%0d.ready", i), 32'(ready), 32'd1);
            tick();
        end

        // Clear request with a colliding write: write dropped, whole array and scoreboard zeroed.
        applyStimulus(5'd3, 5'd4, 5'd4, 32'hFF, 1'b1, 1'b0, 5'd0, 1'b1);
        checkOutput("clr");
        cmp("clr.preRd", rd1, 32'hA5);
        tick();
        waitClear("clr");
        tick();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(5'(i), 5'(i + 16), 5'd0, '0, 1'b0, 1'b0, 5'd0, 1'b0);
            checkOutput("clrPend");
            cmp("clrPend.p1", 32'(pend1), 32'd0);
            cmp("clrPend.p2", 32'(pend2), 32'd0);
            tick();
        end

        // Clear interrupted by reset at cycle 10: the full 32-cycle clear restarts.
        applyStimulus(5'd3, 5'd4, 5'd3, 32'hA5, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(5'd3, 5'd4, 5'd4, 32'hFF, 1'b1, 1'b0, 5'd0, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(5'd3, 5'd4, 5'd0, '0, 1'b0, 1'b0, 5'd0, 1'b0);
            checkOutput("rstClr");
            tick();
        end
        rst_n = 1'b0;
        modelReset();
        checkOutput("rstHeld");
        cmp("rstHeld.ready", 32'(ready), 32'd0);
        tick();
        rst_n = 1'b1;
        waitClear("rstClr");
        tick();

        // Random traffic with clustered addresses to provoke collisions.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), $urandom_range(0, 59) == 0);
            checkOutput("rand");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
